// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter: round-robin burst arbiter feeding the write port of an async FIFO.
// Rev 1.0
`default_nettype none

module cdc_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk_a_i,
  input  logic                          a_rst_ni,
  input  logic                          arb_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_we_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  input  logic                          fifo_wrdy_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o,
  output logic [15:0]                   stat_words_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [CNT_W-1:0] burst_cnt;
  logic [15:0]      stat_words;

  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  scan_id;
  logic             pick_found;
  logic [ID_W-1:0]  next_ptr;
  logic             xfer;
  logic             burst_end;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && req_valid_i[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  assign xfer      = (state == BURST) & req_valid_i[grant_id] & fifo_wrdy_i;
  assign burst_end = xfer & (req_last_i[grant_id] | (burst_cnt == CNT_W'(BURST_MAX - 1)));
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (state == BURST) begin
      req_ready_o[grant_id] = fifo_wrdy_i;
    end
  end

  assign fifo_we_o    = xfer;
  assign fifo_din_o   = (state == BURST) ? req_data_i[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy_o       = (state == BURST);
  assign grant_id_o   = grant_id;
  assign stat_words_o = stat_words;

  always_ff @(posedge clk_a_i or negedge a_rst_ni) begin
    if (!a_rst_ni) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      burst_cnt  <= '0;
      stat_words <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en_i && pick_found) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          // Grant is held (no timeout) until last word or the burst limit.
          if (xfer) begin
            stat_words <= stat_words + 16'd1;
            burst_cnt  <= burst_cnt + 1'b1;
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdc_wr_arbiter.sv
// tb_cdc_wr_arbiter: directed scoreboard bench for cdc_wr_arbiter (4 requesters, 8-bit, burst 4).
`default_nettype none

module tb_cdc_wr_arbiter;

  logic        clk_a_i = 1'b0;
  logic        a_rst_ni;
  logic        arb_en_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic        fifo_we_o;
  logic [7:0]  fifo_din_o;
  logic        fifo_wrdy_i;
  logic [1:0]  grant_id_o;
  logic        busy_o;
  logic [15:0] stat_words_o;

  cdc_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_MAX(4)) dut (
    .clk_a_i     (clk_a_i),
    .a_rst_ni    (a_rst_ni),
    .arb_en_i    (arb_en_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .fifo_we_o   (fifo_we_o),
    .fifo_din_o  (fifo_din_o),
    .fifo_wrdy_i (fifo_wrdy_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o),
    .stat_words_o(stat_words_o)
  );

  always #5 clk_a_i = ~clk_a_i;

  // Source words per requester: {last, data}.
  logic [8:0]  src_q [4][$];
  // Expected FIFO writes: {requester id, data}.
  logic [9:0]  sb_q [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input logic [7:0] d, input logic last);
    src_q[k].push_back({last, d});
    sb_q.push_back({2'(k), d});
  endtask

  // Source driver: present head word at +2, retire it at +4 if accepted.
  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    forever begin
      @(negedge clk_a_i);
      #2;
      for (int k = 0; k < 4; k++) begin
        if (src_q[k].size() > 0) begin
          req_valid_i[k]       = 1'b1;
          req_data_i[k*8 +: 8] = src_q[k][0][7:0];
          req_last_i[k]        = src_q[k][0][8];
        end else begin
          req_valid_i[k]       = 1'b0;
          req_data_i[k*8 +: 8] = 8'h00;
          req_last_i[k]        = 1'b0;
        end
      end
      #2;
      for (int k = 0; k < 4; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) void'(src_q[k].pop_front());
      end
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  initial begin
    logic [9:0] exp_w;
    forever begin
      @(negedge clk_a_i);
      #4;
      cyc++;
      if (fifo_we_o) begin
        wr_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_write", {22'd0, grant_id_o, fifo_din_o}, 32'hFFFF_FFFF);
        end else begin
          exp_w = sb_q.pop_front();
          check("wr_id", {30'd0, grant_id_o}, {30'd0, exp_w[9:8]});
          check("wr_data", {24'd0, fifo_din_o}, {24'd0, exp_w[7:0]});
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_a_i);
      n++;
    end while (!(sb_q.size() == 0 && !busy_o) && n < 200);
    check(name, {31'd0, (sb_q.size() == 0 && !busy_o)}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_we"},    {31'd0, fifo_we_o},  32'd0);
    check({name, "_busy"},  {31'd0, busy_o},     32'd0);
    check({name, "_ready"}, {28'd0, req_ready_o}, 32'd0);
    check({name, "_din"},   {24'd0, fifo_din_o}, 32'd0);
  endtask

  initial begin
    int n;
    a_rst_ni    = 1'b0;
    arb_en_i    = 1'b1;
    fifo_wrdy_i = 1'b1;
    repeat (3) @(negedge clk_a_i);
    #1;
    check_idle_outputs("rst");
    check("rst_stat", {16'd0, stat_words_o}, 32'd0);
    @(negedge clk_a_i);
    a_rst_ni = 1'b1;

    // Single requester 2, three-word packet, back-to-back writes.
    wr_cyc.delete();
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    drain("t1_drain");
    check("t1_nwr", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) begin
      check("t1_gap01", wr_cyc[1] - wr_cyc[0], 32'd1);
      check("t1_gap12", wr_cyc[2] - wr_cyc[1], 32'd1);
    end
    check("t1_stat", {16'd0, stat_words_o}, 32'd3);

    // All requesters valid with one-word packets; rr_ptr starts at 3.
    wr_cyc.delete();
    for (int k = 0; k < 4; k++) src_q[k].push_back({1'b1, 8'(k * 16 + 1)});
    for (int k = 0; k < 4; k++) src_q[k].push_back({1'b1, 8'(k * 16 + 2)});
    sb_q.push_back({2'd3, 8'h31}); sb_q.push_back({2'd0, 8'h01});
    sb_q.push_back({2'd1, 8'h11}); sb_q.push_back({2'd2, 8'h21});
    sb_q.push_back({2'd3, 8'h32}); sb_q.push_back({2'd0, 8'h02});
    sb_q.push_back({2'd1, 8'h12}); sb_q.push_back({2'd2, 8'h22});
    drain("t2_drain");
    check("t2_nwr", wr_cyc.size(), 32'd8);
    for (int i = 1; i < wr_cyc.size(); i++) check("t2_gap", wr_cyc[i] - wr_cyc[i-1], 32'd2);
    check("t2_stat", {16'd0, stat_words_o}, 32'd11);

    // Requester 1 streams without last; burst limit splits it, 2 and 3 interleave.
    for (int i = 0; i < 12; i++) src_q[1].push_back({1'b0, 8'(8'h50 + i)});
    src_q[3].push_back({1'b1, 8'hC0});
    src_q[2].push_back({1'b1, 8'hE0});
    sb_q.push_back({2'd3, 8'hC0});
    for (int i = 0; i < 4; i++) sb_q.push_back({2'd1, 8'(8'h50 + i)});
    sb_q.push_back({2'd2, 8'hE0});
    for (int i = 4; i < 12; i++) sb_q.push_back({2'd1, 8'(8'h50 + i)});
    drain("t3_drain");
    check("t3_stat", {16'd0, stat_words_o}, 32'd25);

    // FIFO full for five cycles mid-burst.
    load(0, 8'h70, 1'b0); load(0, 8'h71, 1'b0); load(0, 8'h72, 1'b0); load(0, 8'h73, 1'b1);
    n = 0;
    do begin
      @(negedge clk_a_i);
      n++;
    end while (sb_q.size() > 2 && n < 100);
    check("t4_reach", sb_q.size(), 32'd2);
    fifo_wrdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      check("t4_stall_we", {31'd0, fifo_we_o}, 32'd0);
      check("t4_stall_rdy", {28'd0, req_ready_o}, 32'd0);
      @(negedge clk_a_i);
    end
    check("t4_stall_stat", {16'd0, stat_words_o}, 32'd27);
    fifo_wrdy_i = 1'b1;
    drain("t4_drain");
    check("t4_stat", {16'd0, stat_words_o}, 32'd29);

    // Arbitration disabled: no grant while requester 1 waits.
    arb_en_i = 1'b0;
    load(1, 8'h81, 1'b1);
    repeat (5) begin
      @(negedge clk_a_i);
      #1;
      check("t5_nogrant", {31'd0, busy_o}, 32'd0);
    end
    arb_en_i = 1'b1;
    drain("t5_drain1");
    // Disable mid-burst: requester 2 finishes, requester 3 stays waiting.
    load(2, 8'h91, 1'b0); load(2, 8'h92, 1'b0); load(2, 8'h93, 1'b1);
    src_q[3].push_back({1'b1, 8'hA0});
    n = 0;
    do begin
      @(negedge clk_a_i);
      n++;
    end while (!busy_o && n < 50);
    arb_en_i = 1'b0;
    drain("t5_drain2");
    repeat (5) begin
      @(negedge clk_a_i);
      #1;
      check("t5_hold_idle", {31'd0, busy_o}, 32'd0);
    end
    check("t5_stat", {16'd0, stat_words_o}, 32'd33);

    // Reset mid-burst of requester 2, rr_ptr=2 beforehand.
    arb_en_i = 1'b1;
    sb_q.push_back({2'd3, 8'hA0});
    drain("t6_drain_a0");
    load(1, 8'hD1, 1'b1);
    drain("t6_drain_d1");
    for (int i = 0; i < 4; i++) src_q[2].push_back({i == 3, 8'(8'hB0 + i)});
    sb_q.push_back({2'd2, 8'hB0}); sb_q.push_back({2'd2, 8'hB1});
    n = 0;
    do begin
      @(negedge clk_a_i);
      n++;
    end while (sb_q.size() > 0 && n < 50);
    check("t6_pre_stat", {16'd0, stat_words_o}, 32'd37);
    a_rst_ni = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    check("t6_rst_stat", {16'd0, stat_words_o}, 32'd0);
    load(0, 8'hE0, 1'b1);
    sb_q.push_back({2'd2, 8'hB2}); sb_q.push_back({2'd2, 8'hB3});
    @(negedge clk_a_i);
    #1;
    check("t6_rst_we", {31'd0, fifo_we_o}, 32'd0);
    @(negedge clk_a_i);
    a_rst_ni = 1'b1;
    drain("t6_drain_post");
    check("t6_post_stat", {16'd0, stat_words_o}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cdc_wr_arbiter.md
CDC_WR_ARBITER -- requirements
Module: cdc_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each data word.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter BURST_MAX, default 4, maximum words per grant (1..16).
REQ-004 clk_a_i  input  1  write-side clock; all logic in this domain.
REQ-005 a_rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 arb_en_i  input  1  1 = new grants allowed; 0 = finish current burst, then no new grants.
REQ-007 req_valid_i  input  NUM_REQ  per-requester word valid.
REQ-008 req_data_i  input  NUM_REQ*DATA_WIDTH  packed words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last_i  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid_i.
REQ-010 req_ready_o  output  NUM_REQ  per-requester word accepted when valid&ready.
REQ-011 fifo_we_o  output  1  write enable to the async FIFO write port.
REQ-012 fifo_din_o  output  DATA_WIDTH  write data to the FIFO.
REQ-013 fifo_wrdy_i  input  1  FIFO not-full.
REQ-014 grant_id_o  output  $clog2(NUM_REQ)  index of current grant holder; valid when busy_o=1.
REQ-015 busy_o  output  1  1 while in BURST state.
REQ-016 stat_words_o  output  16  total words written to FIFO, wraps 0xFFFF->0x0000.

Function
REQ-017 Two-state FSM: IDLE, BURST.
REQ-018 IDLE: if arb_en_i=1 and any req_valid_i set, select the first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; register it in grant_id_o and go to BURST next cycle, with burst count cleared to 0.
REQ-019 IDLE: all req_ready_o=0, fifo_we_o=0.
REQ-020 BURST: req_ready_o[grant_id_o]=fifo_wrdy_i; all other req_ready_o bits 0.
REQ-021 BURST: fifo_we_o=req_valid_i[grant_id_o] & fifo_wrdy_i; fifo_din_o=granted requester's word (combinational, zero latency).
REQ-022 Transfer = fifo_we_o=1; each transfer increments burst count and stat_words_o by 1.
REQ-023 BURST -> IDLE on a transfer with req_last_i[grant_id_o]=1, or on the transfer making burst count equal BURST_MAX.
REQ-024 On BURST -> IDLE, rr_ptr <= (grant_id_o+1) mod NUM_REQ; rr_ptr is unchanged otherwise.
REQ-025 Grant is held while the holder deasserts valid mid-burst or FIFO is full; no timeout, no preemption.
REQ-026 arb_en_i deassertion during BURST does not end the burst.
REQ-027 At least one IDLE cycle between consecutive grants; max throughput BURST_MAX words per BURST_MAX+1 cycles.
REQ-028 When fifo_wrdy_i=0, no transfer occurs, and no counter or pointer changes.
REQ-029 fifo_din_o = 0 when not in BURST.
REQ-030 Simultaneous last flag and burst-limit on the same transfer: single exit to IDLE, with rr_ptr advanced once.

Reset
REQ-031 a_rst_ni=0 asynchronously forces state=IDLE, rr_ptr=0, grant_id_o=0, burst count=0, stat_words_o=0.
REQ-032 During reset and until the first BURST: req_ready_o=0, fifo_we_o=0, fifo_din_o=0, busy_o=0.
REQ-033 Reset asserted mid-burst abandons the burst with no further writes; after release, arbitration restarts from requester 0.

Verification
REQ-034 Single requester 2, 3-word packet (0xA1,0xA2,0xA3 with last on 0xA3), FIFO ready -> IDLE 1 cycle, 3 consecutive writes, busy_o falls, stat_words_o=3, rr_ptr=3.
REQ-035 All 4 requesters valid continuously with 1-word packets -> grants in order 0,1,2,3,0; each grant separated by one IDLE cycle.
REQ-036 Requester 1 streams 10 words with no last, BURST_MAX=4 -> grant released after words 4 and 8; requester 1 regranted only when no other valid requester precedes it in round-robin order.
REQ-037 fifo_wrdy_i=0 for 5 cycles mid-burst -> fifo_we_o=0 and req_ready_o=0 throughout; no data lost or duplicated; burst resumes when fifo_wrdy_i returns to 1.
REQ-038 arb_en_i=0 while requesters are valid -> no grant; arb_en_i dropped mid-burst -> burst completes, then FSM stays in IDLE.
REQ-039 a_rst_ni pulsed low after the 2nd word of a burst -> outputs zero immediately, stat_words_o=0; after release, requester 0 is granted first if valid.
